// File: rtl/reg_index_encoder.sv
// Serialising register-bitmap encoder: emits the index of each set mask bit,
// lowest first, one per out handshake. Inverse of the 5-to-32 select decoder.
module reg_index_encoder #(
  parameter int WIDTH    = 32,
  parameter int SEL_BITS = 5,
  parameter int CNT_BITS = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [WIDTH-1:0]    load_mask,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SEL_BITS-1:0] out_select,
  output logic                out_last,
  output logic [CNT_BITS-1:0] remaining,
  output logic                busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  logic [0:0]          state_reg, state_next;
  logic [WIDTH-1:0]    pending_reg, pending_next;
  logic [WIDTH-1:0]    lowest;
  logic [SEL_BITS-1:0] sel_enc;
  logic [CNT_BITS-1:0] pop_cnt;
  logic                single_bit;
  logic                emit;

  // Isolate the lowest set bit; the encoder below only ever sees a one-hot value.
  assign lowest     = pending_reg & (~pending_reg + WIDTH'(1));
  assign single_bit = (pending_reg != '0) &&
                      ((pending_reg & (pending_reg - WIDTH'(1))) == '0);

  // Each select bit is the OR of the one-hot positions whose index has that bit set.
  generate
    for (genvar gi = 0; gi < SEL_BITS; gi++) begin : g_enc
      logic [WIDTH-1:0] col;
      for (genvar gj = 0; gj < WIDTH; gj++) begin : g_col
        assign col[gj] = 1'((gj >> gi) & 1);
      end
      assign sel_enc[gi] = |(lowest & col);
    end
  endgenerate

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_cnt = pop_cnt + CNT_BITS'(pending_reg[i]);
    end
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    if (flush) begin
      state_next   = ST_IDLE;
      pending_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // An all-zero mask is accepted and dropped without entering EMIT.
          if (load_valid && (load_mask != '0)) begin
            pending_next = load_mask;
            state_next   = ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            pending_next = pending_reg & ~lowest;
            if (single_bit) begin
              state_next = ST_IDLE;
            end
          end
        end
        default: begin
          state_next   = ST_IDLE;
          pending_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      pending_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
    end
  end

  // Outputs depend on registered state only, so they hold steady through stalls.
  assign emit       = (state_reg == ST_EMIT);
  assign load_ready = !emit;
  assign busy       = emit;
  assign out_valid  = emit;
  assign out_select = emit ? sel_enc : '0;
  assign out_last   = emit && single_bit;
  assign remaining  = emit ? pop_cnt : '0;

endmodule

// File: tb/tb_reg_index_encoder.sv
// Directed bench for reg_index_encoder; a queue holds the expected index
// stream, popped on each out handshake.
module tb_reg_index_encoder;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_mask;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_select;
  logic        out_last;
  logic [5:0]  remaining;
  logic        busy;

  typedef struct packed {
    logic [4:0] sel;
    logic       last;
    logic [5:0] rem;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   failures;

  reg_index_encoder dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_mask  (load_mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_select (out_select),
    .out_last   (out_last),
    .remaining  (remaining),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_mask(input logic [31:0] m);
    int n;
    int k;
    exp_t e;
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(m[i]);
    k = 0;
    for (int i = 0; i < 32; i++) begin
      if (m[i]) begin
        e.sel  = 5'(i);
        e.last = (k == n - 1);
        e.rem  = 6'(n - k);
        q.push_back(e);
        k++;
      end
    end
  endtask

  // Compare the current output against the scoreboard head, pop on handshake, advance.
  task automatic cycle();
    exp_t e;
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_valid", 32'(out_valid), 32'd0);
      end else begin
        e = q[0];
        chk("select", 32'(out_select), 32'(e.sel));
        chk("last", 32'(out_last), 32'(e.last));
        chk("remaining", 32'(remaining), 32'(e.rem));
        chk("busy", 32'(busy), 32'd1);
        chk("load_ready_emit", 32'(load_ready), 32'd0);
        if (out_ready && !flush && !reset) void'(q.pop_front());
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_load_ready"}, 32'(load_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_remaining"}, 32'(remaining), 32'd0);
    chk({tag, "_select"}, 32'(out_select), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
  endtask

  // Expect n consecutive valid cycles, then idle with the scoreboard drained.
  task automatic run_expect(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      chk({tag, "_consecutive_valid"}, 32'(out_valid), 32'd1);
      cycle();
    end
    check_idle({tag, "_done"});
    chk({tag, "_sb_empty"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    flush      = 1'b0;
    load_valid = 1'b0;
    load_mask  = '0;
    out_ready  = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    check_idle("reset");

    // Zero mask: accepted, nothing emitted
    load_valid = 1'b1;
    load_mask  = 32'h0000_0000;
    cycle();
    load_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_idle("zero_mask");
      cycle();
    end

    // Sparse mask with top bit
    out_ready  = 1'b1;
    load_valid = 1'b1;
    load_mask  = 32'h8000_0005;
    push_mask(load_mask);
    cycle();
    load_valid = 1'b0;
    run_expect(3, "sparse");

    // Full mask
    load_valid = 1'b1;
    load_mask  = 32'hFFFF_FFFF;
    push_mask(load_mask);
    cycle();
    load_valid = 1'b0;
    chk("full_first_remaining", 32'(remaining), 32'd32);
    run_expect(32, "full");

    // Stall for three cycles
    out_ready  = 1'b0;
    load_valid = 1'b1;
    load_mask  = 32'h0000_0110;
    push_mask(load_mask);
    cycle();
    load_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_select", 32'(out_select), 32'd4);
      cycle();
    end
    out_ready = 1'b1;
    run_expect(2, "stall");

    // Flush after first accept
    load_valid = 1'b1;
    load_mask  = 32'h0F00_0000;
    push_mask(load_mask);
    cycle();
    load_valid = 1'b0;
    cycle();
    chk("flush_pre_select", 32'(out_select), 32'd25);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    q.delete();
    check_idle("flush");
    load_valid = 1'b1;
    load_mask  = 32'h0000_0002;
    push_mask(load_mask);
    cycle();
    load_valid = 1'b0;
    run_expect(1, "post_flush");

    // Reset in the middle of EMIT with load and out handshakes pending
    load_valid = 1'b1;
    load_mask  = 32'h0000_00F0;
    push_mask(load_mask);
    cycle();
    load_valid = 1'b0;
    cycle();
    reset      = 1'b1;
    load_valid = 1'b1;
    load_mask  = 32'h0000_AAAA;
    out_ready  = 1'b1;
    cycle();
    reset      = 1'b0;
    load_valid = 1'b0;
    q.delete();
    check_idle("mid_reset");
    cycle();
    check_idle("mid_reset_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
